// File: rtl/femto_ahbl_pkg.sv
// Shared encodings for the femto AHB-lite responders: HSIZE codes and the
// SRAM responder state values.
package femto_ahbl_pkg;

    localparam logic [1:0] HSIZE_B = 2'd0;
    localparam logic [1:0] HSIZE_H = 2'd1;
    localparam logic [1:0] HSIZE_W = 2'd2;

    // State values are plain constants so older tools can consume the package.
    typedef logic [2:0] ahbl_slv_st_e;

    localparam ahbl_slv_st_e ST_IDLE    = 3'd0;
    localparam ahbl_slv_st_e ST_WR      = 3'd1;
    localparam ahbl_slv_st_e ST_RD_REQ  = 3'd2;
    localparam ahbl_slv_st_e ST_RD_WAIT = 3'd3;
    localparam ahbl_slv_st_e ST_RD_DATA = 3'd4;
    localparam ahbl_slv_st_e ST_ERR1    = 3'd5;
    localparam ahbl_slv_st_e ST_ERR2    = 3'd6;

endpackage

// File: rtl/ahbl_addr_chk.sv
// Address-phase checker: flags transfers this responder must reject
// (illegal size, misalignment, outside the address window) and derives the
// byte-lane mask of the addressed bytes within the 32-bit word.
module ahbl_addr_chk #(
    parameter int          AW        = 10,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
    input  logic [31:0] haddr,
    input  logic [1:0]  hsize,
    output logic        fault,
    output logic [3:0]  lane_mask
);
    import femto_ahbl_pkg::*;

    logic bad_shape;
    logic out_win;
    logic unused_mid_bits;

    // Word-offset bits only select the SRAM row; they never make a transfer illegal.
    assign unused_mid_bits = ^haddr[AW+1:2];

    // Size decode: lane mask plus alignment / illegal-size detection.
    always_comb begin
        bad_shape = 1'b0;
        lane_mask = 4'b0000;
        case (hsize)
            HSIZE_B: lane_mask = 4'b0001 << haddr[1:0];
            HSIZE_H: begin
                lane_mask = 4'b0011 << {haddr[1], 1'b0};
                bad_shape = haddr[0];
            end
            HSIZE_W: begin
                lane_mask = 4'b1111;
                bad_shape = (haddr[1:0] != 2'b00);
            end
            default: bad_shape = 1'b1;
        endcase
    end

    assign out_win = (haddr[31:AW+2] != BASE_ADDR[31:AW+2]);
    assign fault   = bad_shape | out_win;

endmodule

// File: rtl/ahbl_sram_slv.sv
// AHB-lite responder in front of a single-port synchronous SRAM.
// Writes complete with zero wait states; reads take 2+WAIT data-phase
// cycles; rejected transfers get the two-cycle ERROR response.
module ahbl_sram_slv #(
    parameter int          AW        = 10,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          WAIT      = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          hsel,
    input  logic [31:0]   haddr,
    input  logic          hprot,
    input  logic [1:0]    hsize,
    input  logic          hwrite,
    input  logic          htrans,
    input  logic [31:0]   hwdata,
    output logic [31:0]   hrdata,
    output logic          hresp,
    output logic          hready,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [3:0]    sram_be,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);
    import femto_ahbl_pkg::*;

    ahbl_slv_st_e  state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    mask_q, mask_d;

    logic          accept;
    logic          fault;
    logic [3:0]    lane_mask;
    logic          cnt_zero;
    logic          unused_hprot;

    // Data and instruction fetches are treated identically.
    assign unused_hprot = hprot;

    ahbl_addr_chk #(
        .AW        (AW),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_chk (
        .haddr     (haddr),
        .hsize     (hsize),
        .fault     (fault),
        .lane_mask (lane_mask)
    );

    // hready depends only on state_q, so this has no combinational loop.
    assign accept = hsel & htrans & hready;

    // First data-phase state of a freshly accepted transfer.
    function automatic ahbl_slv_st_e accept_dest(input logic flt, input logic wr);
        if (flt)
            return ST_ERR1;
        else if (wr)
            return ST_WR;
        else
            return ST_RD_REQ;
    endfunction

    // Next-state and address-phase capture.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        if (accept) begin
            addr_d = haddr[AW+1:2];
            mask_d = lane_mask;
        end
        case (state_q)
            ST_IDLE, ST_WR, ST_RD_DATA, ST_ERR2:
                state_d = accept ? accept_dest(fault, hwrite) : ST_IDLE;
            ST_RD_REQ:
                state_d = (WAIT > 0) ? ST_RD_WAIT : ST_RD_DATA;
            ST_RD_WAIT:
                if (cnt_zero) state_d = ST_RD_DATA;
            ST_ERR1:
                state_d = ST_ERR2;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // Bus response and SRAM strobes are pure decodes of the current state.
    always_comb begin
        hready     = 1'b1;
        hresp      = 1'b0;
        hrdata     = 32'h0;
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = 4'b0000;
        sram_wdata = 32'h0;
        case (state_q)
            ST_WR: begin
                sram_ce    = 1'b1;
                sram_we    = 1'b1;
                sram_be    = mask_q;
                sram_wdata = hwdata;
            end
            ST_RD_REQ: begin
                hready  = 1'b0;
                sram_ce = 1'b1;
                sram_be = mask_q;
            end
            ST_RD_WAIT: hready = 1'b0;
            ST_RD_DATA: hrdata = sram_rdata;
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    assign sram_addr = addr_q;

    // Control state: cleared asynchronously so an in-flight access is dropped at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Latched transfer attributes; only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        mask_q <= mask_d;
    end

    generate
        if (WAIT > 0) begin : g_wait
            localparam int CW = $clog2(WAIT + 1);
            localparam logic [CW-1:0] WAIT_LD = CW'(WAIT - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            // Wait-state counter: loaded while the read strobe is out, counts down in RD_WAIT.
            always_comb begin
                cnt_d = cnt_q;
                if (state_q == ST_RD_REQ)
                    cnt_d = WAIT_LD;
                else if ((state_q == ST_RD_WAIT) && (cnt_q != '0))
                    cnt_d = cnt_q - CW'(1);
            end

            // Counter register.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    cnt_q <= '0;
                else
                    cnt_q <= cnt_d;
            end

            assign cnt_zero = (cnt_q == '0);
        end else begin : g_nowait
            assign cnt_zero = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_ahbl_sram_slv.sv
// Bench for ahbl_sram_slv (WAIT=2): table of bus transfers driven as a
// pipelined AHB master with an expected-result queue, plus hand-written
// reset and deselect sequences.
module tb_ahbl_sram_slv;

    localparam int          AW_P    = 10;
    localparam logic [31:0] BASE_P  = 32'h2000_0000;
    localparam int          WAIT_P  = 2;
    localparam int          NVEC    = 18;
    localparam int          BUDGET  = 400;

    logic            clk = 1'b0;
    logic            rstn;
    logic            hsel, hprot, hwrite, htrans;
    logic [31:0]     haddr, hwdata;
    logic [1:0]      hsize;
    logic [31:0]     hrdata;
    logic            hresp, hready;
    logic            sram_ce, sram_we;
    logic [3:0]      sram_be;
    logic [AW_P-1:0] sram_addr;
    logic [31:0]     sram_wdata;
    logic [31:0]     sram_rdata;

    bit   [31:0]     mem [0:(1<<AW_P)-1];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [31:0] wdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] rdata;
    } vec_t;

    vec_t vec [0:NVEC-1];
    vec_t sb [$];

    ahbl_sram_slv #(
        .AW        (AW_P),
        .BASE_ADDR (BASE_P),
        .WAIT      (WAIT_P)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .hsel       (hsel),
        .haddr      (haddr),
        .hprot      (hprot),
        .hsize      (hsize),
        .hwrite     (hwrite),
        .htrans     (htrans),
        .hwdata     (hwdata),
        .hrdata     (hrdata),
        .hresp      (hresp),
        .hready     (hready),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_be    (sram_be),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous SRAM, read data held until the next strobe.
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive vec[first..last] back to back; compare each transfer when its data phase ends.
    task automatic run_vecs(input int first, input int last);
        int   idx;
        int   cyc;
        int   ncyc;
        int   nce;
        int   ndone;
        bit   dp_v;
        bit   acc;
        vec_t dp;
        vec_t ex;
        logic [3:0] be_seen;
        int   exp_lat;
        idx = first; cyc = 0; ncyc = 0; nce = 0; ndone = first;
        dp_v = 1'b0; be_seen = 4'b0;
        dp = vec[first];
        while ((idx <= last || dp_v) && cyc < BUDGET) begin
            if (idx <= last) begin
                hsel   = 1'b1;
                htrans = 1'b1;
                haddr  = vec[idx].addr;
                hsize  = vec[idx].size;
                hwrite = vec[idx].wr;
                hprot  = idx[0];
            end else begin
                hsel   = 1'b0;
                htrans = 1'b0;
            end
            @(negedge clk);
            cyc++;
            acc = (idx <= last) && hready;
            if (dp_v) begin
                ncyc++;
                chk($sformatf("v%0d_hresp_cyc%0d", ndone, ncyc), {31'b0, hresp}, {31'b0, dp.err});
                if (sram_ce) begin
                    nce++;
                    be_seen = sram_be;
                    chk($sformatf("v%0d_sram_we", ndone), {31'b0, sram_we}, {31'b0, dp.wr});
                    chk($sformatf("v%0d_sram_addr", ndone), {22'b0, sram_addr}, {22'b0, dp.addr[11:2]});
                    if (dp.wr)
                        chk($sformatf("v%0d_sram_wdata", ndone), sram_wdata, dp.wdata);
                end
                if (hready) begin
                    ex = sb.pop_front();
                    exp_lat = ex.err ? 2 : (ex.wr ? 1 : 2 + WAIT_P);
                    chk($sformatf("v%0d_hrdata", ndone), hrdata, ex.rdata);
                    chk($sformatf("v%0d_latency", ndone), ncyc, exp_lat);
                    chk($sformatf("v%0d_ce_count", ndone), nce, ex.err ? 0 : 1);
                    if (!ex.err)
                        chk($sformatf("v%0d_be", ndone), {28'b0, be_seen}, {28'b0, ex.be});
                    dp_v = 1'b0;
                    ndone++;
                end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                dp      = vec[idx];
                dp_v    = 1'b1;
                ncyc    = 0;
                nce     = 0;
                be_seen = 4'b0;
                hwdata  = dp.wr ? dp.wdata : 32'h0;
                sb.push_back(dp);
                idx++;
            end
        end
        if (cyc >= BUDGET)
            chk("run_vecs_timeout", cyc, 0);
        hsel   = 1'b0;
        htrans = 1'b0;
    endtask

    initial begin
        vec[0]  = '{32'h2000_0010, 2'd2, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'hF, 32'h0};
        vec[1]  = '{32'h2000_0010, 2'd2, 1'b0, 32'h0,         1'b0, 4'hF, 32'hDEAD_BEEF};
        vec[2]  = '{32'h2000_0013, 2'd0, 1'b1, 32'hAB00_0000, 1'b0, 4'h8, 32'h0};
        vec[3]  = '{32'h2000_0010, 2'd2, 1'b0, 32'h0,         1'b0, 4'hF, 32'hABAD_BEEF};
        vec[4]  = '{32'h2000_0001, 2'd1, 1'b0, 32'h0,         1'b1, 4'h0, 32'h0};
        vec[5]  = '{32'h3000_0000, 2'd2, 1'b0, 32'h0,         1'b1, 4'h0, 32'h0};
        vec[6]  = '{32'h2000_0020, 2'd3, 1'b0, 32'h0,         1'b1, 4'h0, 32'h0};
        vec[7]  = '{32'h2000_0022, 2'd1, 1'b1, 32'h1234_0000, 1'b0, 4'hC, 32'h0};
        vec[8]  = '{32'h2000_0021, 2'd0, 1'b1, 32'h0000_5600, 1'b0, 4'h2, 32'h0};
        vec[9]  = '{32'h2000_0020, 2'd2, 1'b0, 32'h0,         1'b0, 4'hF, 32'h1234_5600};
        vec[10] = '{32'h2000_0FFC, 2'd2, 1'b1, 32'hCAFE_F00D, 1'b0, 4'hF, 32'h0};
        vec[11] = '{32'h2000_0FFC, 2'd2, 1'b0, 32'h0,         1'b0, 4'hF, 32'hCAFE_F00D};
        vec[12] = '{32'h2000_1000, 2'd2, 1'b1, 32'h1111_1111, 1'b1, 4'h0, 32'h0};
        vec[13] = '{32'h2000_0002, 2'd2, 1'b1, 32'h2222_2222, 1'b1, 4'h0, 32'h0};
        vec[14] = '{32'h2000_0FFF, 2'd0, 1'b0, 32'h0,         1'b0, 4'h8, 32'hCAFE_F00D};
        vec[15] = '{32'h2000_0022, 2'd1, 1'b0, 32'h0,         1'b0, 4'hC, 32'h1234_5600};
        vec[16] = '{32'h2000_0030, 2'd2, 1'b0, 32'h0,         1'b0, 4'hF, 32'h0};
        vec[17] = '{32'h2000_0010, 2'd2, 1'b0, 32'h0,         1'b0, 4'hF, 32'hABAD_BEEF};

        rstn = 1'b0; hsel = 1'b0; htrans = 1'b0; hwrite = 1'b0; hprot = 1'b0;
        haddr = 32'h0; hsize = 2'd0; hwdata = 32'h0;

        #3;
        chk("rst_hready", {31'b0, hready}, 32'h1);
        chk("rst_hresp", {31'b0, hresp}, 32'h0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_sram_ce", {31'b0, sram_ce}, 32'h0);
        chk("rst_sram_we", {31'b0, sram_we}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        run_vecs(0, 15);

        // Reset while waiting on a slow read.
        hsel = 1'b1; htrans = 1'b1; hwrite = 1'b0; hsize = 2'd2; haddr = 32'h2000_0010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 1'b0;
        chk("rdreq_hready", {31'b0, hready}, 32'h0);
        @(posedge clk); #1;
        chk("rdwait_hready", {31'b0, hready}, 32'h0);
        chk("rdwait_ce", {31'b0, sram_ce}, 32'h0);
        rstn = 1'b0;
        #1;
        chk("rdwait_rst_hready", {31'b0, hready}, 32'h1);
        chk("rdwait_rst_ce", {31'b0, sram_ce}, 32'h0);
        chk("rdwait_rst_hresp", {31'b0, hresp}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Reset during a write data phase: the write must not reach the SRAM.
        hsel = 1'b1; htrans = 1'b1; hwrite = 1'b1; hsize = 2'd2; haddr = 32'h2000_0030;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 1'b0; hwdata = 32'h5555_AAAA;
        chk("wr_ce", {31'b0, sram_ce}, 32'h1);
        rstn = 1'b0;
        #1;
        chk("wr_rst_ce", {31'b0, sram_ce}, 32'h0);
        chk("wr_rst_we", {31'b0, sram_we}, 32'h0);
        chk("wr_rst_hready", {31'b0, hready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Transfer offered with hsel low, then with htrans low: neither is taken.
        hsel = 1'b0; htrans = 1'b1; hwrite = 1'b0; hsize = 2'd2; haddr = 32'h2000_0010;
        @(posedge clk); #1;
        chk("nosel_ce", {31'b0, sram_ce}, 32'h0);
        chk("nosel_hready", {31'b0, hready}, 32'h1);
        hsel = 1'b1; htrans = 1'b0;
        @(posedge clk); #1;
        chk("notrans_ce", {31'b0, sram_ce}, 32'h0);
        chk("notrans_hready", {31'b0, hready}, 32'h1);
        hsel = 1'b0;

        run_vecs(16, 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
